spi_ram_ctrl_p: RTL and testbench



---
 rtl/spi_ram_ctrl_p.sv | 122 ++++++++++++
 tb/tb_spi_ram_ctrl_p.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl_p.sv
// spi_ram_ctrl_p: SPI command decoder in front of a single-port RAM (write/read address + data).
// Defining SPI_RAM_BURST_EN enables burst reads (RDATA payload = word count).
module spi_ram_ctrl_p #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RDATA = 2'b11;

`ifdef SPI_RAM_BURST_EN
  typedef enum logic {ST_IDLE, ST_BURST} state_t;
`else
  typedef enum logic {ST_IDLE} state_t;
`endif

  // rx: a command is consumed on every clock with rx_valid=1 (no backpressure);
  // tx: tx_valid is a one-cycle pulse per word, with no ready from the serializer.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  state_t            r_state;
`ifdef SPI_RAM_BURST_EN
  logic              r_busy;
  logic [ADDR_W-1:0] r_rd_count;
`endif

  logic [1:0]        w_op;
  logic [ADDR_W-1:0] w_payload;
  logic              w_wr_en;
  logic              w_rd_cmd;
  logic              w_burst_start;

  assign w_op      = rx_data[ADDR_W+1:ADDR_W];
  assign w_payload = rx_data[ADDR_W-1:0];
  assign w_wr_en   = rst_n && rx_valid && (w_op == OP_WDATA);
  assign w_rd_cmd  = rx_valid && (w_op == OP_RDATA);
`ifdef SPI_RAM_BURST_EN
  assign w_burst_start = (w_payload != '0);
`else
  assign w_burst_start = 1'b0;
`endif

  // Writes land this edge, so an RDATA on the next cycle sees the new word.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_addr] <= w_payload[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
`ifdef SPI_RAM_BURST_EN
      r_busy     <= 1'b0;
      r_rd_count <= '0;
`endif
    end else begin
      r_tx_valid <= 1'b0;
      if (rx_valid && (w_op == OP_WADDR)) r_wr_addr <= w_payload;
      else if (w_wr_en && (AUTO_INC != 0)) r_wr_addr <= r_wr_addr + ADDR_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (rx_valid && (w_op == OP_RADDR)) r_rd_addr <= w_payload;
          if (w_rd_cmd && w_burst_start) begin
`ifdef SPI_RAM_BURST_EN
            r_state    <= ST_BURST;
            r_busy     <= 1'b1;
            r_rd_count <= w_payload;
`endif
          end else if (w_rd_cmd) begin
            r_tx_data  <= r_mem[r_rd_addr];
            r_tx_valid <= 1'b1;
            if (AUTO_INC != 0) r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
`ifdef SPI_RAM_BURST_EN
        // Burst always walks the address; RADDR/RDATA arriving now are dropped.
        ST_BURST: begin
          r_tx_data  <= r_mem[r_rd_addr];
          r_tx_valid <= 1'b1;
          r_rd_addr  <= r_rd_addr + ADDR_W'(1);
          r_rd_count <= r_rd_count - ADDR_W'(1);
          if (r_rd_count == ADDR_W'(1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
`ifdef SPI_RAM_BURST_EN
  assign busy     = r_busy;
  assign rd_count = r_rd_count;
`else
  assign busy     = 1'b0;
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_spi_ram_ctrl_p.sv
// Bench for spi_ram_ctrl_p: two instances (AUTO_INC=1 and AUTO_INC=0) share one stimulus
// stream; a reference model predicts read words, their cycle, busy and rd_count.
module tb_spi_ram_ctrl_p;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1;
  logic       busy0, busy1;
  logic [7:0] cnt0, cnt1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  logic [7:0] m_mem [2][256];
  logic [7:0] m_wa [2];
  logic [7:0] m_ra [2];
  int         m_left [2];
  logic       exp_busy_pend = 1'b0, exp_busy_cur = 1'b0;
  logic [7:0] exp_cnt_pend = '0, exp_cnt_cur = '0;

  spi_ram_ctrl_p #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(1)) u_dut_inc (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .busy(busy0), .rd_count(cnt0)
  );

  spi_ram_ctrl_p #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(0)) u_dut_hold (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .busy(busy1), .rd_count(cnt1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    exp_busy_cur <= exp_busy_pend;
    exp_cnt_cur  <= exp_cnt_pend;
  end

  // reference model: one call describes what the coming clock edge does
  task automatic push_word(input int j, input logic [7:0] d);
    exp_t e;
    e.d = d;
    e.c = cyc + 1;
    if (j == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic model_step(input logic r, input logic v, input logic [1:0] op, input logic [7:0] p);
    for (int j = 0; j < 2; j++) begin
      if (!r) begin
        m_wa[j] = 8'd0;
        m_ra[j] = 8'd0;
        m_left[j] = 0;
      end else if (m_left[j] > 0) begin
        push_word(j, m_mem[j][m_ra[j]]);
        m_ra[j] = m_ra[j] + 8'd1;
        m_left[j] = m_left[j] - 1;
        if (v && op == 2'd0) m_wa[j] = p;
        if (v && op == 2'd1) begin
          m_mem[j][m_wa[j]] = p;
          if (j == 0) m_wa[j] = m_wa[j] + 8'd1;
        end
      end else if (v) begin
        case (op)
          2'd0: m_wa[j] = p;
          2'd1: begin
            m_mem[j][m_wa[j]] = p;
            if (j == 0) m_wa[j] = m_wa[j] + 8'd1;
          end
          2'd2: m_ra[j] = p;
          default: begin
`ifdef SPI_RAM_BURST_EN
            if (p != 8'd0) m_left[j] = p;
            else begin
`else
            begin
`endif
              push_word(j, m_mem[j][m_ra[j]]);
              if (j == 0) m_ra[j] = m_ra[j] + 8'd1;
            end
          end
        endcase
      end
    end
    exp_busy_pend = (m_left[0] > 0);
    exp_cnt_pend  = 8'(m_left[0]);
  endtask

  // driver
  task automatic drive(input logic r, input logic v, input logic [1:0] op, input logic [7:0] p);
    @(posedge clk);
    #1;
    rst_n    = r;
    rx_valid = v;
    rx_data  = {op, p};
    model_step(r, v, op, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 2'd0, 8'($urandom_range(0, 255)));
  endtask

  // monitor / scoreboard
  task automatic check_inst(input int j, input logic v, input logic [7:0] d,
                            input logic b, input logic [7:0] c);
    exp_t e;
    int   qs;
    qs = (j == 0) ? exp_q0.size() : exp_q1.size();
    if (v) begin
      total++;
      if (qs == 0) begin
        bad++;
        $display("FAIL tx_unexpected inst%0d cyc=%0d: got tx_valid=1 data=%h, required tx_valid=0", j, cyc, d);
      end else begin
        if (j == 0) e = exp_q0.pop_front();
        else e = exp_q1.pop_front();
        if (d !== e.d || cyc != e.c) begin
          bad++;
          $display("FAIL tx_word inst%0d: got data=%h at cyc %0d, required data=%h at cyc %0d", j, d, cyc, e.d, e.c);
        end
      end
    end else if (qs != 0) begin
      e = (j == 0) ? exp_q0[0] : exp_q1[0];
      if (e.c <= cyc) begin
        total++;
        bad++;
        $display("FAIL tx_missing inst%0d cyc=%0d: got tx_valid=0, required word %h", j, cyc, e.d);
        if (j == 0) void'(exp_q0.pop_front());
        else void'(exp_q1.pop_front());
      end
    end
    total++;
    if (b !== exp_busy_cur) begin
      bad++;
      $display("FAIL busy inst%0d cyc=%0d: got %b, required %b", j, cyc, b, exp_busy_cur);
    end
    total++;
    if (c !== exp_cnt_cur) begin
      bad++;
      $display("FAIL rd_count inst%0d cyc=%0d: got %0d, required %0d", j, cyc, c, exp_cnt_cur);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check_inst(0, tx_valid0, tx_data0, busy0, cnt0);
      check_inst(1, tx_valid1, tx_data1, busy1, cnt1);
    end
  end

  // stimulus
  initial begin
    logic       r, v;
    logic [1:0] op;
    logic [7:0] p;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    for (int j = 0; j < 2; j++) begin
      m_wa[j] = 8'd0;
      m_ra[j] = 8'd0;
      m_left[j] = 0;
    end
    drive(1'b0, 1'b0, 2'd0, 8'd0);
    drive(1'b0, 1'b0, 2'd0, 8'd0);

    // preload every address in both instances
    for (int a = 0; a < 256; a++) begin
      drive(1'b1, 1'b1, 2'd0, 8'(a));
      drive(1'b1, 1'b1, 2'd1, 8'($urandom_range(0, 255)));
    end

    // basic write then read back
    drive(1'b1, 1'b1, 2'd0, 8'h10);
    drive(1'b1, 1'b1, 2'd1, 8'hA5);
    drive(1'b1, 1'b1, 2'd2, 8'h10);
    drive(1'b1, 1'b1, 2'd3, 8'h00);
    idle(2);

    // address wrap at 0xFF
    drive(1'b1, 1'b1, 2'd0, 8'hFF);
    drive(1'b1, 1'b1, 2'd1, 8'h11);
    drive(1'b1, 1'b1, 2'd1, 8'h22);
    drive(1'b1, 1'b1, 2'd2, 8'hFF);
    drive(1'b1, 1'b1, 2'd3, 8'h00);
    drive(1'b1, 1'b1, 2'd3, 8'h00);
    idle(2);

    // overwrite at a held address
    drive(1'b1, 1'b1, 2'd0, 8'h05);
    drive(1'b1, 1'b1, 2'd1, 8'h33);
    drive(1'b1, 1'b1, 2'd1, 8'h44);
    drive(1'b1, 1'b1, 2'd2, 8'h05);
    drive(1'b1, 1'b1, 2'd3, 8'h00);

    // reset with rx_valid high must not write; outputs clear
    drive(1'b0, 1'b1, 2'd1, 8'hEE);
    drive(1'b0, 1'b1, 2'd1, 8'hEE);
    @(negedge clk);
    total++;
    if (tx_data0 !== 8'h00 || tx_data1 !== 8'h00) begin
      bad++;
      $display("FAIL reset_tx_data: got %h/%h, required 00/00", tx_data0, tx_data1);
    end
    drive(1'b1, 1'b1, 2'd2, 8'h00);
    drive(1'b1, 1'b1, 2'd3, 8'h00);
    idle(2);

    // burst of 4 from 0x20
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'd0, 8'(8'h20 + i));
      drive(1'b1, 1'b1, 2'd1, 8'(i + 1));
    end
    drive(1'b1, 1'b1, 2'd2, 8'h20);
    drive(1'b1, 1'b1, 2'd3, 8'd4);
    idle(6);

    // burst of 8 interrupted by reset after the third word
    drive(1'b1, 1'b1, 2'd2, 8'h20);
    drive(1'b1, 1'b1, 2'd3, 8'd8);
    idle(3);
    drive(1'b0, 1'b0, 2'd0, 8'd0);
    drive(1'b1, 1'b1, 2'd2, 8'h21);
    drive(1'b1, 1'b1, 2'd3, 8'h00);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 99) != 0);
      v  = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3) p = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 6)) : 8'd0;
      else p = 8'($urandom_range(0, 255));
      drive(r, v, op, p);
    end
    idle(20);

    @(negedge clk);
    total++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d/%0d words outstanding, required 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
